// File: rtl/teclado_emulador.sv
// teclado_emulador -- responder-side model of a 4x4 keypad matrix.
//
// Accepts a key code over a valid/ready handshake, then "presses" that key:
// the row line of the key follows its column line for HOLD_SCANS counted
// column visits, stays released for RELEASE_SCANS visits, then pulses done.
// A visit is a rising edge of the key's column line. If no visit arrives for
// TIMEOUT_CYC cycles the sequence aborts and err pulses.
//
// Optional build macro: TECLADO_REBOTE_EN adds contact bounce on pressed for
// the first BOUNCE_CYCLES cycles of each phase. Visits are ignored while the
// bounce is active.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   col[3:0]   column lines from the scanner (active-high)
//   key_code   [3:2] row index, [1:0] column index; sampled at acceptance
//   key_valid  press request
//   key_ready  request can be accepted (IDLE)
//   fila[3:0]  row lines to the scanner, combinational from col
//   pressed    current effective key state
//   done       one-cycle pulse, sequence completed
//   err        one-cycle pulse, sequence aborted on timeout
module teclado_emulador #(
  parameter int HOLD_SCANS    = 4,
  parameter int RELEASE_SCANS = 2,
  parameter int TIMEOUT_CYC   = 1024,
  parameter int BOUNCE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic [3:0] fila,
  output logic       pressed,
  output logic       done,
  output logic       err
);

  localparam int MAX_SCANS = (HOLD_SCANS > RELEASE_SCANS) ? HOLD_SCANS : RELEASE_SCANS;
  localparam int VW        = $clog2(MAX_SCANS + 1);
  localparam int TW        = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    r_q, r_d;
  logic [1:0]    c_q, c_d;
  logic          col_prev_q, col_prev_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic col_hit;
  logic accept;
  logic visit;
  logic in_bounce;

  assign col_hit   = col[c_q];
  assign accept    = key_valid && (state_q == IDLE);
  assign key_ready = (state_q == IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign fila      = (pressed && col_hit) ? (4'b0001 << r_q) : 4'b0000;

`ifdef TECLADO_REBOTE_EN
  localparam int BW = $clog2(BOUNCE_CYCLES + 1);

  logic [BW-1:0] bcnt_q, bcnt_d;

  assign in_bounce = (int'(bcnt_q) < BOUNCE_CYCLES);

  // Bounce phase counter restarts on every state change; its LSB gives the
  // alternating contact pattern.
  always_comb begin
    bcnt_d = bcnt_q;
    if ((state_q == IDLE) || (state_d != state_q)) begin
      bcnt_d = '0;
    end else if (in_bounce) begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  always_comb begin
    pressed = 1'b0;
    if (state_q == PRESS) begin
      pressed = in_bounce ? ~bcnt_q[0] : 1'b1;
    end else if (state_q == RELEASE) begin
      pressed = in_bounce & bcnt_q[0];
    end
  end
`else
  assign in_bounce = 1'b0;
  assign pressed   = (state_q == PRESS);
`endif

  assign visit = (state_q != IDLE) && col_hit && !col_prev_q && !in_bounce;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    vcnt_d  = vcnt_q;
    tcnt_d  = tcnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    // On acceptance the edge detector already tracks the new column, so a
    // column that is high at entry is not seen as a visit.
    col_prev_d = accept ? col[key_code[1:0]] : col_hit;

    unique case (state_q)
      IDLE: begin
        vcnt_d = '0;
        tcnt_d = '0;
        if (key_valid) begin
          r_d     = key_code[3:2];
          c_d     = key_code[1:0];
          state_d = PRESS;
        end
      end
      PRESS, RELEASE: begin
        // A visit takes priority over a timeout in the same cycle.
        if (visit) begin
          tcnt_d = '0;
          if (int'(vcnt_q) + 1 == ((state_q == PRESS) ? HOLD_SCANS : RELEASE_SCANS)) begin
            vcnt_d = '0;
            if (state_q == PRESS) begin
              state_d = RELEASE;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            vcnt_d = vcnt_q + 1'b1;
          end
        end else if (int'(tcnt_q) + 1 >= TIMEOUT_CYC) begin
          state_d = IDLE;
          err_d   = 1'b1;
          vcnt_d  = '0;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      r_q        <= '0;
      c_q        <= '0;
      col_prev_q <= 1'b0;
      vcnt_q     <= '0;
      tcnt_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      col_prev_q <= col_prev_d;
      vcnt_q     <= vcnt_d;
      tcnt_q     <= tcnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_teclado_emulador.sv
// Bench for teclado_emulador: a scoreboard queue holds the expected output
// vector {fila, pressed, key_ready, done, err} for each cycle as stimulus is
// driven; it is popped and compared once the outputs have settled.
module tb_teclado_emulador;

  localparam int HOLD    = 4;
  localparam int REL     = 2;
  localparam int TMO     = 1024;
  localparam int BOUNCE  = 3;
  localparam int SEQ_MAX = 200;

  typedef struct packed {
    logic [3:0] fila;
    logic       pressed;
    logic       key_ready;
    logic       done;
    logic       err;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col = 4'b0000;
  logic [3:0] key_code = 4'b0000;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic [3:0] fila;
  logic       pressed;
  logic       done;
  logic       err;

  int vectors = 0;
  int miscompares = 0;
  obs_t exp_q[$];

  teclado_emulador #(
    .HOLD_SCANS   (HOLD),
    .RELEASE_SCANS(REL),
    .TIMEOUT_CYC  (TMO),
    .BOUNCE_CYCLES(BOUNCE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .fila     (fila),
    .pressed  (pressed),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.fila      = fila;
    o.pressed   = pressed;
    o.key_ready = key_ready;
    o.done      = done;
    o.err       = err;
    return o;
  endfunction

  function automatic obs_t mk(input logic [3:0] f, input logic p, input logic rdy,
                              input logic d, input logic e);
    obs_t o;
    o.fila      = f;
    o.pressed   = p;
    o.key_ready = rdy;
    o.done      = d;
    o.err       = e;
    return o;
  endfunction

  // Expected pressed level st cycles after entering PRESS (in_press=1) or RELEASE.
  function automatic logic exp_pressed(input bit in_press, input int st);
`ifdef TECLADO_REBOTE_EN
    if (st < BOUNCE) return in_press ? (st % 2 == 0) : (st % 2 == 1);
`endif
    return in_press;
  endfunction

  function automatic bit visit_counts(input int st);
`ifdef TECLADO_REBOTE_EN
    return st >= BOUNCE;
`else
    return (st >= 0);
`endif
  endfunction

  // Column index k cycles after the accept cycle: held on the key's column
  // for the first 'hold' cycles, then rotating from i0.
  function automatic int col_idx(input int k, input int c, input int i0, input int hold);
    if (k < hold) return c;
    return (i0 + k - hold) % 4;
  endfunction

  task automatic run_seq(input logic [3:0] code, input int i0, input int hold,
                         input bit busy, input string name);
    int r, c, id, vis, st, phase;
    bit prev, hit, fin, pr;
    logic [3:0] oh;
    obs_t e, got;
    r = int'(code[3:2]);
    c = int'(code[1:0]);
    oh = 4'b0001 << code[3:2];
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    id = col_idx(0, c, i0, hold);
    col = 4'b0001 << id;
    prev = (id == c);
    exp_q.push_back(mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
    #1;
    got = observe();
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s accept: observed=%b required=%b (fila,pressed,ready,done,err)", name, got, e);
    end
    phase = 0; vis = 0; st = 0; fin = 1'b0;
    for (int k = 1; k < SEQ_MAX && !fin; k++) begin
      @(negedge clk);
      key_valid = busy && (k <= 12);
      if (busy) key_code = 4'b0000;
      id = col_idx(k, c, i0, hold);
      col = 4'b0001 << id;
      hit = (id == c);
      if (phase == 2) begin
        exp_q.push_back(mk(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0));
        fin = 1'b1;
      end else begin
        pr = exp_pressed(phase == 0, st);
        exp_q.push_back(mk((pr && hit) ? oh : 4'b0000, pr, 1'b0, 1'b0, 1'b0));
        if (hit && !prev && visit_counts(st)) begin
          vis++;
          if (phase == 0 && vis == HOLD) begin
            phase = 1; vis = 0; st = 0;
          end else if (phase == 1 && vis == REL) begin
            phase = 2;
          end else begin
            st++;
          end
        end else begin
          st++;
        end
      end
      prev = hit;
      #1;
      got = observe();
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL %s k=%0d: observed=%b required=%b (fila,pressed,ready,done,err)",
                 name, k, got, e);
      end
    end
    key_valid = 1'b0;
    if (!fin) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: observed no done, required done within %0d cycles", name, SEQ_MAX);
    end
    // done must be a single-cycle pulse
    @(negedge clk);
    col = 4'b0000;
    exp_q.push_back(mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
    #1;
    got = observe();
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s after_done: observed=%b required=%b", name, got, e);
    end
  endtask

  task automatic test_reset();
    obs_t e, got;
    exp_q.push_back(mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
    #2;
    got = observe();
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL reset_state: observed=%b required=%b", got, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_press();
    run_seq(4'b0110, 0, 0, 1'b0, "single_press");
  endtask

  task automatic test_timeout();
    obs_t e, got;
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'b1111;
    col       = 4'b0001;
    for (int k = 0; k <= TMO + 6; k++) begin
      if (k > 0) begin
        @(negedge clk);
        key_valid = 1'b0;
      end
      if (k == 0)
        exp_q.push_back(mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
      else
        exp_q.push_back(mk(4'b0000, (k <= TMO) && exp_pressed(1'b1, k - 1),
                           k > TMO, 1'b0, k == TMO + 1));
      #1;
      got = observe();
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL timeout k=%0d: observed=%b required=%b", k, got, e);
      end
    end
  endtask

  task automatic test_busy();
    run_seq(4'b0110, 0, 0, 1'b1, "busy_press");
    run_seq(4'b0000, 1, 0, 1'b0, "after_busy");
  endtask

  task automatic test_reset_mid();
    obs_t e, got;
    bit found;
    int id;
    found = 1'b0;
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'b0110;
    col       = 4'b0001;
    for (int k = 1; k < 20 && !found; k++) begin
      @(negedge clk);
      key_valid = 1'b0;
      id = k % 4;
      col = 4'b0001 << id;
      #1;
      if (fila == 4'b0010) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL reset_mid_wait: observed fila never 0010, required within 20 cycles");
    end
    #1;
    rst_n = 1'b0;
    exp_q.push_back(mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
    #1;
    got = observe();
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL reset_mid_async: observed=%b required=%b", got, e);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
    got = observe();
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL reset_mid_hold: observed=%b required=%b", got, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(4'b0110, 0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_col_active();
    run_seq(4'b0110, 3, 3, 1'b0, "col_active_entry");
  endtask

  task automatic test_back_to_back();
    run_seq(4'b1001, 2, 0, 1'b0, "b2b_r2c1");
    run_seq(4'b0011, 0, 0, 1'b0, "b2b_r0c3");
    run_seq(4'b1100, 3, 2, 1'b0, "b2b_r3c0");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_timeout();
    test_busy();
    test_reset_mid();
    test_col_active();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/teclado_emulador.md
Name: teclado_emulador

Overview:
Synthesizable 4x4 keypad matrix model: the responder side of the keypad scanner interface. It receives a key code through a valid/ready handshake, watches the column lines driven by the scanner, and drives the row lines as a pressed physical key would. It holds the key for a programmable number of column visits, then releases it for a programmable number of visits. Used in benches and in on-board self-test in place of the real keypad.

Parameters:
HOLD_SCANS, 4, number of counted column visits the key stays pressed (>=1)
RELEASE_SCANS, 2, number of counted column visits the key stays released before done (>=1)
TIMEOUT_CYC, 1024, clk cycles with no counted visit before aborting (>=2)
BOUNCE_CYCLES, 3, bounce window length in clk cycles; used only with TECLADO_REBOTE_EN

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
col  in  4  column lines from the scanner, active-high; one-hot in normal use
key_code  in  4  key to press: [3:2] row index, [1:0] column index
key_valid  in  1  request to press key_code
key_ready  out  1  high when a request can be accepted
fila  out  4  row lines to the scanner, active-high
pressed  out  1  current effective key state
done  out  1  one-cycle pulse: press/release sequence completed
err  out  1  one-cycle pulse: sequence aborted on timeout

Behaviour:
- Reset is asynchronous on rst_n=0. Outputs immediately: key_ready=1, pressed=0, fila=0, done=0, err=0. State goes to IDLE and all counters clear. Reset mid-sequence aborts it and does not pulse done.
- States: IDLE, PRESS, RELEASE.
- IDLE: key_ready=1. When key_valid=1 and key_ready=1 on a clk edge:
  - latch r=key_code[3:2] and c=key_code[1:0];
  - go to PRESS; key_ready=0 from the next cycle.
- key_valid is ignored outside IDLE. key_code is sampled only at acceptance.
- fila is combinational from col:
  - fila = onehot(r) when pressed=1 and col[c]=1, else 4'b0000;
  - other col bits are ignored, so non-one-hot col still responds on bit c;
  - zero-cycle latency from col to fila.
- col_prev is a register of col[c], updated every cycle in every state.
- A visit is a cycle with col[c]=1 and col_prev=0. If col[c] is already high on state entry, that visit does not count.
- PRESS:
  - pressed=1;
  - count visits; on the HOLD_SCANS-th visit go to RELEASE and clear the counters.
- RELEASE:
  - pressed=0;
  - on the RELEASE_SCANS-th visit pulse done for one cycle and go to IDLE;
  - key_ready=1 in the cycle after the final visit edge.
- Timeout:
  - the cycle counter clears on every counted visit and on every state entry;
  - when it reaches TIMEOUT_CYC in PRESS or RELEASE: go to IDLE, pressed=0, err pulses one cycle, done not pulsed.
- If a counted visit and the timeout occur in the same cycle, the visit wins.
- Visit counters are sized $clog2(max(HOLD_SCANS,RELEASE_SCANS)+1) bits and do not wrap. The timeout counter is $clog2(TIMEOUT_CYC+1) bits.
- done and err are never both high in the same cycle.

Optional Feature:
TECLADO_REBOTE_EN
- With the macro defined, contact bounce is injected:
  - for the first BOUNCE_CYCLES clk cycles of PRESS, pressed alternates 1,0,1,... starting at 1, then holds 1;
  - for the first BOUNCE_CYCLES cycles of RELEASE, pressed alternates 0,1,0,... starting at 0, then holds 0;
  - visits inside a bounce window are not counted, but col_prev still updates;
  - the timeout counter runs during bounce.
- Without the macro: pressed steps cleanly, BOUNCE_CYCLES is ignored, and no bounce logic is synthesized.

Test Plan:
- Single press. Bench rotates col 0001->0010->0100->1000 every clk. Send key_code=4'b0110 (r=1, c=2).
  -> fila=4'b0010 exactly in the cycles col=0100, for 4 visits.
  -> Then fila=0 for 2 visits, then one done pulse. key_ready is 0 throughout and 1 after done.
- Non-matching columns. key_code=4'b1111 while col is stuck at 4'b0001.
  -> fila stays 0, no visits are counted.
  -> err pulses after 1024 cycles, done stays 0, state returns to IDLE.
- Busy rejection. Assert key_valid with key_code=4'b0000 during PRESS of key 4'b0110.
  -> Request ignored: fila never equals 4'b0001 for col=0001.
  -> A new handshake succeeds only after done.
- Reset mid-PRESS. Drive rst_n=0 while fila=4'b0010.
  -> fila=0, pressed=0, key_ready=1 combinationally, with no done or err pulse.
  -> After release, a new request completes normally.
- Column already active at entry. col is held at 0100 when key 4'b0110 is accepted.
  -> That visit is not counted; 4 further visits are needed before RELEASE.
- With TECLADO_REBOTE_EN and BOUNCE_CYCLES=3:
  -> pressed shows 1,0,1 then steady 1 at PRESS entry, and 0,1,0 then steady 0 at RELEASE entry.
  -> The done timing equals the clean case plus the visits that fell inside the bounce windows.
